e_mdu: RTL and testbench

- Execute-stage multiply/divide unit that sits beside the ALU.
- Consumes the same forwarded E-stage operands (A = rs value, B = rt value).
- Holds the architectural HI/LO registers; results feed the E/M result mux for mfhi/mflo.
- Multi-cycle. The busy output drives the hazard unit, which stalls any mult/div/mfhi/mflo/mthi/mtlo in D while busy or start is high.

---
 rtl/e_mdu_pkg.sv | 35 +++
 rtl/e_mdu.sv | 222 ++++++++++++++++++++++
 tb/tb_e_mdu.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// -----------------------------------------------------------------------------
// e_mdu_pkg -- shared definitions for the execute-stage multiply/divide unit.
//
// Contents:
//   MDU_* operation encodings (4-bit mdu_op values driven by the decoder)
//   mdu_state_t  : FSM state type (IDLE / RUN)
//   DEFAULT_MULT_CYCLES / DEFAULT_DIV_CYCLES : default busy latencies
// -----------------------------------------------------------------------------
package e_mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NOP   = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd9;
  localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd10;
  localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd11;
  localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd12;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_t;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

endpackage

// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu -- execute-stage multiply/divide unit with architectural HI/LO.
//
// A mult/div is launched when start is sampled high in IDLE. The 64-bit result
// is computed from A/B at that edge and parked in a pending register; the FSM
// then counts down MULT_CYCLES or DIV_CYCLES busy cycles and commits the
// pending value to HI/LO on the final edge. HI/LO never change during RUN.
// start while busy is ignored. Division by zero runs the full latency but does
// not commit.
//
// Optional feature: define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU
// ({HI,LO} +/- A*B, accumulate base sampled at launch, MULT_CYCLES latency).
// Without it those codes behave as NOP.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   start   in   E-stage instruction is an MDU op
//   mdu_op  in   [3:0] operation (MDU_* from e_mdu_pkg)
//   A       in   [31:0] forwarded rs operand
//   B       in   [31:0] forwarded rt operand
//   hi_out  out  [31:0] current HI
//   lo_out  out  [31:0] current LO
//   busy    out  high while a multi-cycle op is in flight
// -----------------------------------------------------------------------------
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] mdu_op,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic [31:0]         hi_out,
  output logic [31:0]         lo_out,
  output logic                busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       hi_q, lo_q;
  logic [63:0]       pend_q;
  logic              pend_commit_q;

  // Decode / arithmetic results for the op presented this cycle.
  logic              launch_op;
  logic              res_commit;
  logic [63:0]       res_val;
  logic [CNT_W-1:0]  res_cnt;

  // ---------------------------------------------------------------------------
  // Arithmetic. Signed products come from sign-extended 64-bit operands: the
  // low 64 bits of that product equal the true signed product. Signed division
  // runs on magnitudes and fixes signs afterwards, which also yields the
  // architected overflow result (0x80000000 / -1 -> LO=0x80000000, HI=0).
  // Divisors are forced nonzero so the dividers never see 0; a zero divide is
  // simply not committed.
  // ---------------------------------------------------------------------------
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] divu_b, a_mag, b_mag, divs_b;
  logic [31:0] quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign a_zx   = {32'd0, A};
  assign b_zx   = {32'd0, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign divu_b = (B == 32'd0) ? 32'd1 : B;
  assign quo_u  = A / divu_b;
  assign rem_u  = A % divu_b;

  assign a_mag  = A[31] ? (32'd0 - A) : A;
  assign b_mag  = B[31] ? (32'd0 - B) : B;
  assign divs_b = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign quo_m  = a_mag / divs_b;
  assign rem_m  = a_mag % divs_b;
  assign quo_s  = (A[31] ^ B[31]) ? (32'd0 - quo_m) : quo_m;
  assign rem_s  = A[31] ? (32'd0 - rem_m) : rem_m;

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    launch_op  = 1'b0;
    res_commit = 1'b0;
    res_val    = 64'd0;
    res_cnt    = '0;
    case (mdu_op)
      MDU_MULT: begin
        launch_op  = 1'b1;
        res_commit = 1'b1;
        res_val    = prod_s;
        res_cnt    = CNT_W'(MULT_CYCLES);
      end
      MDU_MULTU: begin
        launch_op  = 1'b1;
        res_commit = 1'b1;
        res_val    = prod_u;
        res_cnt    = CNT_W'(MULT_CYCLES);
      end
      MDU_DIV: begin
        launch_op  = 1'b1;
        res_commit = (B != 32'd0);
        res_val    = {rem_s, quo_s};
        res_cnt    = CNT_W'(DIV_CYCLES);
      end
      MDU_DIVU: begin
        launch_op  = 1'b1;
        res_commit = (B != 32'd0);
        res_val    = {rem_u, quo_u};
        res_cnt    = CNT_W'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        launch_op  = 1'b1;
        res_commit = 1'b1;
        res_val    = {hi_q, lo_q} + prod_s;
        res_cnt    = CNT_W'(MULT_CYCLES);
      end
      MDU_MADDU: begin
        launch_op  = 1'b1;
        res_commit = 1'b1;
        res_val    = {hi_q, lo_q} + prod_u;
        res_cnt    = CNT_W'(MULT_CYCLES);
      end
      MDU_MSUB: begin
        launch_op  = 1'b1;
        res_commit = 1'b1;
        res_val    = {hi_q, lo_q} - prod_s;
        res_cnt    = CNT_W'(MULT_CYCLES);
      end
      MDU_MSUBU: begin
        launch_op  = 1'b1;
        res_commit = 1'b1;
        res_val    = {hi_q, lo_q} - prod_u;
        res_cnt    = CNT_W'(MULT_CYCLES);
      end
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MDU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (start && launch_op)   state_d = MDU_RUN;
      MDU_RUN:  if (cnt_q == CNT_W'(1))   state_d = MDU_IDLE;
      default:                            state_d = MDU_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == MDU_RUN);
  end

  // ---------------------------------------------------------------------------
  // Datapath: counter, pending result, HI/LO.
  // ---------------------------------------------------------------------------
  // NOTE: the pending result is reset along with HI/LO so an aborted op can
  // never leak into a later commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      pend_q        <= 64'd0;
      pend_commit_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            if (launch_op) begin
              pend_q        <= res_val;
              pend_commit_q <= res_commit;
              cnt_q         <= res_cnt;
            end else if (mdu_op == MDU_MTHI) begin
              hi_q <= A;
            end else if (mdu_op == MDU_MTLO) begin
              lo_q <= A;
            end
          end
        end
        MDU_RUN: begin
          // start is deliberately not looked at here: ops issued while busy
          // are dropped.
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            pend_commit_q <= 1'b0;
            if (pend_commit_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// -----------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu (default latencies 5 / 10).
// Directed vector table, hand sequences for ignored start and reset mid-op,
// then random ops against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MC = DEFAULT_MULT_CYCLES;
  localparam int DC = DEFAULT_DIV_CYCLES;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] a_in, b_in;
  logic [31:0] hi_out, lo_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Architectural HI/LO as the bench believes them to be.
  logic [31:0] cur_hi, cur_lo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .A      (a_in),
    .B      (b_in),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one op on HI/LO plus busy length.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
    int sa, sb;
    longint la, lb, q, r, ps;
    longint unsigned ua, ub, pu, acc;
    sa = a; sb = b; la = sa; lb = sb; ua = a; ub = b;
    lat = 0;
    case (op)
      MDU_MULT:  begin ps = la * lb; {hi, lo} = ps; lat = MC; end
      MDU_MULTU: begin pu = ua * ub; {hi, lo} = pu; lat = MC; end
      MDU_DIV: begin
        lat = DC;
        if (b != 0) begin q = la / lb; r = la % lb; lo = q[31:0]; hi = r[31:0]; end
      end
      MDU_DIVU: begin
        lat = DC;
        if (b != 0) begin pu = ua / ub; acc = ua % ub; lo = pu[31:0]; hi = acc[31:0]; end
      end
      MDU_MTHI: hi = a;
      MDU_MTLO: lo = a;
`ifdef MDU_MADD_EN
      MDU_MADD:  begin acc = {hi, lo}; ps = la * lb; acc = acc + ps; {hi, lo} = acc; lat = MC; end
      MDU_MADDU: begin acc = {hi, lo}; acc = acc + ua * ub;        {hi, lo} = acc; lat = MC; end
      MDU_MSUB:  begin acc = {hi, lo}; ps = la * lb; acc = acc - ps; {hi, lo} = acc; lat = MC; end
      MDU_MSUBU: begin acc = {hi, lo}; acc = acc - ua * ub;        {hi, lo} = acc; lat = MC; end
`endif
      default: ;
    endcase
  endfunction

  // Issue one op, count busy cycles, verify HI/LO hold while busy and the
  // final values. inject_at >= 1 drives a MULT start during that busy cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat,
                        input int inject_at);
    int  lat;
    bit  held;
    @(negedge clk);
    start = 1'b1; mdu_op = op; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NOP; a_in = $urandom; b_in = $urandom;
    lat = 0;
    held = 1'b1;
    while (busy && lat < 200) begin
      lat++;
      if (hi_out !== cur_hi || lo_out !== cur_lo) held = 1'b0;
      if (lat == inject_at) begin
        start = 1'b1; mdu_op = MDU_MULT; a_in = 32'd3; b_in = 32'd3;
      end
      @(negedge clk);
      start = 1'b0; mdu_op = MDU_NOP;
    end
    check({tag, " busy_cycles"}, 64'(lat), 64'(exp_lat));
    check({tag, " hold_while_busy"}, {63'd0, held}, 64'd1);
    check({tag, " hi"}, {32'd0, hi_out}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo_out}, {32'd0, exp_lo});
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int nb, nh;
    logic [3:0]  rop;
    logic [31:0] ra, rb, mh, ml;
    int          mlat;
    logic [3:0]  pool[11];

    // Sequential directed vectors: each row starts from the previous result.
    vecs[0]  = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MC};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DC};
    vecs[4]  = '{MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000001, 32'h00000003, DC};
    vecs[5]  = '{MDU_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'h00000003, 0};
    vecs[6]  = '{MDU_MFHI,  32'hDEADBEEF, 32'h00000000, 32'h12345678, 32'h00000003, 0};
    vecs[7]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vecs[8]  = '{MDU_MTLO,  32'h00000005, 32'h00000000, 32'h00000000, 32'h00000005, 0};
`ifdef MDU_MADD_EN
    vecs[9]  = '{MDU_MADD,  32'h00000003, 32'h00000004, 32'h00000000, 32'h00000011, MC};
    vecs[10] = '{MDU_MSUBU, 32'h00000001, 32'h00000012, 32'hFFFFFFFF, 32'hFFFFFFFF, MC};
    vecs[11] = '{4'd15,     32'h00000009, 32'h00000009, 32'hFFFFFFFF, 32'hFFFFFFFF, 0};
`else
    vecs[9]  = '{MDU_MADD,  32'h00000003, 32'h00000004, 32'h00000000, 32'h00000005, 0};
    vecs[10] = '{MDU_MSUBU, 32'h00000001, 32'h00000012, 32'h00000000, 32'h00000005, 0};
    vecs[11] = '{4'd15,     32'h00000009, 32'h00000009, 32'h00000000, 32'h00000005, 0};
`endif

    pool = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO,
             MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU, MDU_MFLO};

    // Reset.
    reset = 1'b1; start = 1'b0; mdu_op = MDU_NOP; a_in = 32'd0; b_in = 32'd0;
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hi", {32'd0, hi_out}, 64'd0);
    check("reset lo", {32'd0, lo_out}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset busy", {63'd0, busy}, 64'd0);
    cur_hi = 32'd0; cur_lo = 32'd0;

    // Directed table.
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].lat, -1);

    // Divide by zero with a MULT start injected while busy: must be ignored.
    run_op("mtlo_prep", MDU_MTLO, 32'h00000003, 32'd0, cur_hi, 32'h00000003, 0, -1);
    run_op("divz_ignore", MDU_DIVU, 32'h00000007, 32'h00000000, cur_hi, cur_lo, DC, 3);
    nb = 0;
    repeat (MC + 3) begin
      if (busy) nb++;
      @(negedge clk);
    end
    check("ignored start no relaunch", 64'(nb), 64'd0);
    check("ignored start hi", {32'd0, hi_out}, {32'd0, cur_hi});

    // Random ops against the model.
    for (int n = 0; n < 60; n++) begin
      rop = pool[$urandom_range(10, 0)];
      ra  = $urandom;
      case ($urandom_range(7, 0))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(9, 1);
        2:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3:       rb = 32'hFFFFFFFF - $urandom_range(5, 0);
        default: rb = $urandom;
      endcase
      mh = cur_hi; ml = cur_lo;
      model(rop, ra, rb, mh, ml, mlat);
      run_op($sformatf("rnd%0d op%0d", n, rop), rop, ra, rb, mh, ml, mlat, -1);
    end

    // Reset in the third busy cycle of a MULT: immediate clear, no commit.
    run_op("mthi_prep", MDU_MTHI, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D, cur_lo, 0, -1);
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; a_in = 32'd5; b_in = 32'd7;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NOP;
    repeat (2) @(negedge clk);
    check("mid-op busy before reset", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid-op reset busy", {63'd0, busy}, 64'd0);
    check("mid-op reset hi", {32'd0, hi_out}, 64'd0);
    check("mid-op reset lo", {32'd0, lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nb = 0; nh = 0;
    repeat (DC) begin
      @(negedge clk);
      if (busy) nb++;
      if (hi_out !== 32'd0 || lo_out !== 32'd0) nh++;
    end
    check("after reset no busy", 64'(nb), 64'd0);
    check("after reset no commit", 64'(nh), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
